// File: rtl/sram_like_data_slave_pkg.sv
// Shared bus widths, size encodings and response-queue entry
// for the SRAM-like data-side slave.
package sram_like_data_slave_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  cnt;
  } resp_ent_t;

endpackage

// File: rtl/sram_like_data_slave_if.sv
// SRAM-like data bus: address-phase request plus in-order
// data_ok response, with harness-driven stall.
interface sram_like_data_slave_if;
  import sram_like_data_slave_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic              stall;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr,
    output wstrb, wdata, stall,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr,
    input  wstrb, wdata, stall,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_data_slave_resp_fifo.sv
// Circular response queue; each entry counts down its own
// remaining latency and the head is due once it reaches zero.
module sram_resp_fifo
  import sram_like_data_slave_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_wr,
  input  logic [DATA_W-1:0] push_rdata,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              head_due,
  output logic              head_wr,
  output logic [DATA_W-1:0] head_rdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] CNT0 = CNT_W'(LATENCY - 1);

  resp_ent_t     q [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign head_due   = q[head].vld && (q[head].cnt == '0);
  assign head_wr    = q[head].wr;
  assign head_rdata = q[head].rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++)
        q[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        if (q[i].vld && q[i].cnt != '0)
          q[i].cnt <= q[i].cnt - 1'b1;
      if (pop) begin
        q[head].vld <= 1'b0;
        head        <= head + 1'b1;
      end
      // a pushed slot is never the head being popped
      if (push) begin
        q[tail] <= '{vld: 1'b1, wr: push_wr,
                     rdata: push_rdata, cnt: CNT0};
        tail    <= tail + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_data_slave.sv
// Data-side SRAM-like slave: byte-lane word memory plus a
// fixed-latency in-order response queue.
module sram_like_data_slave
  import sram_like_data_slave_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 4
) (
  input  logic clk,
  input  logic resetn,
  sram_like_data_slave_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  full;
  logic                  empty;
  logic                  head_due;
  logic                  head_wr;
  logic [DATA_W-1:0]     head_rdata;
  logic                  unused_bits;

  assign idx = bus.addr[DEPTH_LOG2+1:2];
  assign unused_bits = ^{bus.size, bus.addr[1:0],
                         bus.addr[ADDR_W-1:DEPTH_LOG2+2]};

  // resetn gates addr_ok directly so it drops with reset
  assign bus.addr_ok = resetn && !bus.stall && !full;
  assign accept      = bus.req && bus.addr_ok;
  assign bus.data_ok = !empty && head_due;
  assign bus.rdata   = (bus.data_ok && !head_wr)
                       ? head_rdata : '0;

  always_ff @(posedge clk) begin
    if (accept && bus.wr)
      for (int i = 0; i < STRB_W; i++)
        if (bus.wstrb[i])
          mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
  end

  sram_resp_fifo #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (resetn),
    .push       (accept),
    .push_wr    (bus.wr),
    .push_rdata (mem[idx]),
    .pop        (bus.data_ok),
    .full       (full),
    .empty      (empty),
    .head_due   (head_due),
    .head_wr    (head_wr),
    .head_rdata (head_rdata)
  );

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Bench for sram_like_data_slave: scoreboarded default config
// plus a directed LATENCY=3/QDEPTH=2 backpressure instance.
module tb_sram_like_data_slave;

  typedef struct {
    logic [31:0] rd;
    int          due;
  } exp_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   n_asrt;
  int   n_fail;
  exp_t sb[$];
  logic [31:0] mdl [1024];

  sram_like_data_slave_if b0();
  sram_like_data_slave_if b1();

  sram_like_data_slave u0 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b0)
  );

  sram_like_data_slave #(
    .LATENCY (3),
    .QDEPTH  (2)
  ) u1 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard pop/compare for the default instance
  always @(negedge clk) begin
    bit exp_dok;
    exp_dok = (sb.size() != 0) && (sb[0].due == cyc);
    chk("data_ok0", 32'(b0.data_ok), 32'(exp_dok));
    if (b0.data_ok && sb.size() != 0) begin
      chk("rdata0", b0.rdata, sb[0].rd);
      void'(sb.pop_front());
    end else if (!b0.data_ok) begin
      chk("rdata0_idle", b0.rdata, 32'h0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic op0(input logic w,
                     input logic [1:0] sz,
                     input logic [31:0] a,
                     input logic [3:0] s,
                     input logic [31:0] d);
    int   i;
    exp_t e;
    b0.req   = 1'b1;
    b0.wr    = w;
    b0.size  = sz;
    b0.addr  = a;
    b0.wstrb = s;
    b0.wdata = d;
    #3;
    chk("addr_ok0", 32'(b0.addr_ok), 32'h1);
    if (b0.addr_ok) begin
      i = int'((a >> 2) & 32'h3FF);
      if (w) begin
        for (int l = 0; l < 4; l++)
          if (s[l]) mdl[i][8*l +: 8] = d[8*l +: 8];
        e.rd = 32'h0;
      end else begin
        e.rd = mdl[i];
      end
      e.due = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    b0.req = 1'b0;
  endtask

  logic [8:0] t_aok;
  logic [8:0] t_dok;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_asrt   = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    b0.req   = 1'b0; b0.wr    = 1'b0;
    b0.size  = 2'd2; b0.addr  = '0;
    b0.wstrb = '0;   b0.wdata = '0;
    b0.stall = 1'b0;
    b1.req   = 1'b0; b1.wr    = 1'b1;
    b1.size  = 2'd2; b1.addr  = 32'h40;
    b1.wstrb = 4'hF; b1.wdata = 32'h5A5A5A5A;
    b1.stall = 1'b0;
    #2;
    chk("rst_addr_ok0", 32'(b0.addr_ok), 32'h0);
    chk("rst_data_ok0", 32'(b0.data_ok), 32'h0);
    chk("rst_rdata0", b0.rdata, 32'h0);
    chk("rst_addr_ok1", 32'(b1.addr_ok), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1);

    op0(1, 2, 32'h0, 4'hF, 32'd1);
    op0(1, 2, 32'h4, 4'hF, 32'd2);
    op0(1, 2, 32'h8, 4'hF, 32'd3);
    op0(1, 2, 32'hC, 4'hF, 32'd4);
    op0(0, 2, 32'h0, 4'h0, 32'h0);
    op0(0, 2, 32'h4, 4'h0, 32'h0);
    op0(0, 2, 32'h8, 4'h0, 32'h0);
    op0(0, 2, 32'hC, 4'h0, 32'h0);
    idle(4);

    op0(1, 2, 32'h2000, 4'hF, 32'h12345678);
    op0(0, 2, 32'h2000, 4'h0, 32'h0);
    idle(4);

    op0(1, 2, 32'h1000, 4'hF, 32'hDEADBEEF);
    op0(0, 2, 32'h1000, 4'h0, 32'h0);
    idle(4);
    op0(1, 0, 32'h1001, 4'b0010, 32'h0000AB00);
    op0(0, 2, 32'h1000, 4'h0, 32'h0);
    idle(4);
    op0(1, 2, 32'h1000, 4'h0, 32'hFFFFFFFF);
    op0(0, 2, 32'h1000, 4'h0, 32'h0);
    op0(0, 2, 32'h1000 + (1 << 12), 4'h0, 32'h0);
    idle(4);

    // narrow queue: req held high, bit c = cycle c
    t_aok = 9'b1_0011_0011;
    t_dok = 9'b1_1001_1000;
    b1.req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) b1.req = 1'b0;
      #3;
      chk($sformatf("addr_ok1_c%0d", c),
          32'(b1.addr_ok), 32'(t_aok[c]));
      chk($sformatf("data_ok1_c%0d", c),
          32'(b1.data_ok), 32'(t_dok[c]));
      chk("rdata1_wr", b1.rdata, 32'h0);
      @(posedge clk);
      #1;
    end
    idle(2);
    b1.stall = 1'b1;
    b1.req   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("stall_addr_ok1", 32'(b1.addr_ok), 32'h0);
      chk("stall_data_ok1", 32'(b1.data_ok), 32'h0);
      @(posedge clk);
      #1;
    end
    b1.stall = 1'b0;
    b1.req   = 1'b0;
    idle(2);

    op0(0, 2, 32'h1000, 4'h0, 32'h0);
    op0(0, 2, 32'h0004, 4'h0, 32'h0);
    sb.delete();
    #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_addr_ok0", 32'(b0.addr_ok), 32'h0);
    chk("mid_rst_data_ok0", 32'(b0.data_ok), 32'h0);
    chk("mid_rst_rdata0", b0.rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(6);
    op0(0, 2, 32'h1000, 4'h0, 32'h0);
    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
